shift_seq: RTL and testbench
============================

# shift_seq

Multi-cycle sequential shift/rotate unit for the execute stage. It is the area-reduced alternative to the single-cycle barrel rotator and shares its operand conventions: a 16-bit operand, a 4-bit count, and one of ROL/SLL/ROR/SRA. It latches an operation on a start pulse, performs one bit position per clock, and presents a registered result with a one-cycle `done` strobe for the writeback mux.

## Interface
- No parameters; datapath width fixed at 16, count width fixed at 4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only when `ready`=1.
- `In`  in  16  operand; captured on an accepted start.
- `Cnt`  in  4  shift/rotate amount, 0–15; captured on an accepted start.
- `Op`  in  2  operation: 00 ROL, 01 SLL, 10 ROR, 11 SRA; captured on an accepted start.
- `Out`  out  16  result register; valid while `done`=1 and held until the next accepted start.
- `done`  out  1  high for exactly one cycle when `Out` holds a completed result.
- `ready`  out  1  high when a start will be accepted (state IDLE or DONE).

## Operation
- Internal registers:
  - `acc[15:0]` drives `Out` directly.
  - `rem[3:0]` holds the bits remaining.
  - `op_q[1:0]` holds the captured operation.
  - `state` is one of IDLE, SHIFT, DONE.
- Accept:
  - Condition: `start`=1 and `ready`=1 at a rising edge.
  - Effect: `acc`<=`In`, `rem`<=`Cnt`, `op_q`<=`Op`.
  - Next state: DONE if `Cnt`==0, else SHIFT.
- Per-edge step in SHIFT, with `acc` = a:
  - ROL: {a[14:0],a[15]}.
  - SLL: {a[14:0],1'b0}.
  - ROR: {a[0],a[15:1]}.
  - SRA: {a[15],a[15:1]}.
  - In the same edge, `rem`<=`rem`-1.
  - If `rem`==1 before decrement, state<=DONE; else stay in SHIFT.
- DONE:
  - `done`=1 (decoded from state).
  - Next edge: accept if `start`=1 (back-to-back), else go to IDLE.
- IDLE: `done`=0, `ready`=1; `acc` and `Out` hold their values.
- `start` while in SHIFT is ignored (not queued). The requester must hold or re-issue it.
- Inputs `In`/`Cnt`/`Op` are don't-care except at an accepted start. Changing them mid-operation has no effect.
- `rem` never wraps: the decrement occurs only in SHIFT, where `rem`≥1.

## Timing
- Reset values (reset dominates `start` in the same cycle):
  - state=IDLE, `acc`=16'h0000, `rem`=0, `op_q`=0.
  - Hence `Out`=0, `done`=0, `ready`=1.
- Reset asserted mid-operation aborts it. No `done` is produced for the aborted request.
- Latency: start is sampled at the end of cycle 0, and `done`=1 during cycle `Cnt`+1.
  - `Cnt`=0 → `done` in cycle 1 with `Out`=`In`.
  - `Cnt`=15 → `done` in cycle 16.
- Throughput with back-to-back starts: one result per `Cnt`+1 cycles. A start in the DONE cycle overlaps that cycle.
- `Out` changes only on an accept edge or a SHIFT edge. It is stable throughout DONE and IDLE.
- `ready` and `done` are pure decodes of registered state; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then ROL: `In`=16'h8001, `Cnt`=1, `Op`=00, start at cycle 0.
  - Required: `done`=1 only in cycle 2, `Out`=16'h0003; `ready`=0 in cycle 1.
- SRA, maximum count: `In`=16'h8000, `Cnt`=15, `Op`=11.
  - Required: `done` in cycle 16, `Out`=16'hFFFF; `done` low in cycles 1–15.
- ROR then SLL, back-to-back:
  - ROR `In`=16'h0001, `Cnt`=4 → `done` in cycle 5, `Out`=16'h1000.
  - Second start in cycle 5: SLL `In`=16'h00FF, `Cnt`=0 → `done` in cycle 6, `Out`=16'h00FF.
- Busy-ignore:
  - ROL `In`=16'h1234, `Cnt`=8, start cycle 0.
  - Extra start with `In`=16'hFFFF in cycle 3.
  - Required: single `done` in cycle 9, `Out`=16'h3412; no second `done`.
- Reset mid-operation:
  - SLL `In`=16'h0001, `Cnt`=10; assert `rst` in cycle 4.
  - Required: cycle 5 shows `Out`=0, `done`=0, `ready`=1, and no `done` ever for that request.
  - A new ROL `In`=16'hA5A5, `Cnt`=4 then gives `Out`=16'h5A5A.
- Exhaustive check against a reference model: all four `Op` × `Cnt` 0–15 × operands {0x0000, 0xFFFF, 0x8001, 0x5A5A, random}.
  - Required: `Out` matches the model and `done` latency equals `Cnt`+1 for every case.

Source files
------------

// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq
//  Description : Multi-cycle sequential shift/rotate unit. Latches a 16-bit
//                operand, a 4-bit count and an operation on an accepted
//                start, moves the operand one bit position per clock, and
//                presents the registered result with a one-cycle done strobe.
//
//  Ports
//    clk    in   1   rising-edge clock
//    rst    in   1   synchronous, active-high reset
//    start  in   1   request, sampled only while ready=1
//    In     in  16   operand, captured on an accepted start
//    Cnt    in   4   shift/rotate amount 0..15, captured on an accepted start
//    Op     in   2   00 ROL, 01 SLL, 10 ROR, 11 SRA, captured on accept
//    Out    out 16   result register, held until the next accepted start
//    done   out  1   high for exactly one cycle when Out holds a result
//    ready  out  1   high when a start will be accepted (IDLE or DONE)
//
//  Revision    : 1.0  initial release
// ============================================================================
module shift_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Op,
    output logic [15:0] Out,
    output logic        done,
    output logic        ready
);

    // ------------------------------------------------------------------------
    // Operation encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] C_OP_ROL = 2'b00;
    localparam logic [1:0] C_OP_SLL = 2'b01;
    localparam logic [1:0] C_OP_ROR = 2'b10;
    localparam logic [1:0] C_OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] acc_q,   acc_d;
    logic [3:0]  rem_q,   rem_d;
    logic [1:0]  op_q,    op_d;

    // One-position step of the accumulator for the captured operation.
    logic [15:0] step_w;
    // A start is only honoured when the unit is not mid-shift.
    logic        accept_w;

    // ------------------------------------------------------------------------
    // Single-position shifter
    // ------------------------------------------------------------------------
    always_comb begin
        step_w = acc_q;
        unique case (op_q)
            C_OP_ROL: step_w = {acc_q[14:0], acc_q[15]};
            C_OP_SLL: step_w = {acc_q[14:0], 1'b0};
            C_OP_ROR: step_w = {acc_q[0],    acc_q[15:1]};
            C_OP_SRA: step_w = {acc_q[15],   acc_q[15:1]};
            default:  step_w = acc_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        op_d     = op_q;
        accept_w = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                accept_w = start;
                if (start) begin
                    acc_d   = In;
                    rem_d   = Cnt;
                    op_d    = Op;
                    // A zero count needs no shift edges: result is In itself.
                    state_d = (Cnt == 4'd0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                // rem is at least 1 here, so the decrement never wraps.
                acc_d   = step_w;
                rem_d   = rem_q - 4'd1;
                state_d = (rem_q == 4'd1) ? ST_DONE : ST_SHIFT;
            end

            default: begin
                // Unused encoding: recover to a quiescent state.
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= 16'h0000;
            rem_q   <= 4'd0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: pure decodes of registered state, no input-to-output path.
    // ------------------------------------------------------------------------
    assign Out   = acc_q;
    assign done  = (state_q == ST_DONE);
    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // accept_w is kept for readability of the next-state block only.
    logic unused_w;
    assign unused_w = accept_w;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_seq
//  Description : Self-checking bench for shift_seq. Directed scenarios plus
//                a sweep of all operations and counts against a behavioural
//                reference model computed from plain shift arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic [1:0]  Op;
    logic [15:0] Out;
    logic        done;
    logic        ready;

    int tests_run    = 0;
    int tests_failed = 0;

    shift_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (In),
        .Cnt   (Cnt),
        .Op    (Op),
        .Out   (Out),
        .done  (done),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: whole-word arithmetic on the full count.
    // ------------------------------------------------------------------------
    function automatic logic [15:0] model(input logic [15:0] a,
                                          input logic [3:0]  n,
                                          input logic [1:0]  op);
        logic [31:0]        dbl;
        logic signed [15:0] s;
        case (op)
            2'b00: begin dbl = {a, a} << n; return dbl[31:16]; end
            2'b01: return a << n;
            2'b10: begin dbl = {a, a} >> n; return dbl[15:0]; end
            default: begin s = a; return 16'(s >>> n); end
        endcase
    endfunction

    // Drive a request so that it is sampled at the next rising edge; return
    // just after that edge (cycle 1) with inputs scrambled.
    task automatic issue(input logic [15:0] a, input logic [3:0] n,
                         input logic [1:0] op);
        In    = a;
        Cnt   = n;
        Op    = op;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        In    = 16'($urandom);
        Cnt   = 4'($urandom);
        Op    = 2'($urandom);
    endtask

    // Find the first cycle (counting from first_cyc) in which done is high,
    // sampling at falling edges. Returns -1 if none within the budget.
    task automatic wait_done(input int first_cyc, output int cyc);
        cyc = -1;
        for (int c = first_cyc; c < first_cyc + 24; c++) begin
            @(negedge clk);
            if (done) begin
                cyc = c;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b1;
        In    = 16'hBEEF;
        Cnt   = 4'd0;
        Op    = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        tests_run++;
        if (Out !== 16'h0000 || done !== 1'b0 || ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset: Out=%h done=%b ready=%b, want Out=0000 done=0 ready=1",
                     Out, done, ready);
        end
    endtask

    task automatic test_rol_basic;
        int cyc;
        issue(16'h8001, 4'd1, 2'b00);
        tests_run++;
        if (ready !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rol_cycle1: ready=%b done=%b, want ready=0 done=0", ready, done);
        end
        wait_done(1, cyc);
        tests_run++;
        if (cyc !== 2 || Out !== 16'h0003) begin
            tests_failed++;
            $display("FAIL rol_basic: done cycle=%0d Out=%h, want cycle=2 Out=0003", cyc, Out);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rol_done_width: done=%b ready=%b in cycle 3, want 0/1", done, ready);
        end
    endtask

    task automatic test_sra_max;
        int cyc;
        issue(16'h8000, 4'd15, 2'b11);
        wait_done(1, cyc);
        tests_run++;
        if (cyc !== 16 || Out !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sra_max: done cycle=%0d Out=%h, want cycle=16 Out=ffff", cyc, Out);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (Out !== 16'hFFFF || done !== 1'b0 || ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL sra_hold: Out=%h done=%b ready=%b, want ffff 0 1", Out, done, ready);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(16'h0001, 4'd4, 2'b10);
        wait_done(1, cyc);
        tests_run++;
        if (cyc !== 5 || Out !== 16'h1000) begin
            tests_failed++;
            $display("FAIL b2b_ror: done cycle=%0d Out=%h, want cycle=5 Out=1000", cyc, Out);
        end
        // Issue during the DONE cycle: accept overlaps it.
        issue(16'h00FF, 4'd0, 2'b01);
        wait_done(6, cyc);
        tests_run++;
        if (cyc !== 6 || Out !== 16'h00FF) begin
            tests_failed++;
            $display("FAIL b2b_sll: done cycle=%0d Out=%h, want cycle=6 Out=00ff", cyc, Out);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore;
        int cyc;
        int extra;
        issue(16'h1234, 4'd8, 2'b00);
        @(posedge clk);             // into cycle 2
        @(posedge clk);             // into cycle 3
        #1;
        In    = 16'hFFFF;
        Cnt   = 4'd3;
        Op    = 2'b01;
        start = 1'b1;
        @(posedge clk);             // end of cycle 3: must be ignored
        #1;
        start = 1'b0;
        wait_done(4, cyc);
        tests_run++;
        if (cyc !== 9 || Out !== 16'h3412) begin
            tests_failed++;
            $display("FAIL busy_ignore: done cycle=%0d Out=%h, want cycle=9 Out=3412", cyc, Out);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        tests_run++;
        if (extra !== 0 || Out !== 16'h3412) begin
            tests_failed++;
            $display("FAIL busy_second_done: extra dones=%0d Out=%h, want 0 and 3412", extra, Out);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int seen;
        issue(16'h0001, 4'd10, 2'b01);
        @(posedge clk);             // cycle 2
        @(posedge clk);             // cycle 3
        @(posedge clk);             // cycle 4
        #1;
        rst = 1'b1;
        @(posedge clk);             // cycle 5
        #1;
        rst = 1'b0;
        tests_run++;
        if (Out !== 16'h0000 || done !== 1'b0 || ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid: Out=%h done=%b ready=%b, want 0000 0 1", Out, done, ready);
        end
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_done: dones after abort=%0d, want 0", seen);
        end
        issue(16'hA5A5, 4'd4, 2'b00);
        wait_done(1, cyc);
        tests_run++;
        if (cyc !== 5 || Out !== 16'h5A5A) begin
            tests_failed++;
            $display("FAIL reset_mid_recover: done cycle=%0d Out=%h, want cycle=5 Out=5a5a", cyc, Out);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep;
        logic [15:0] pats [5];
        logic [15:0] exp;
        int cyc;
        for (int op = 0; op < 4; op++) begin
            for (int n = 0; n < 16; n++) begin
                pats[0] = 16'h0000;
                pats[1] = 16'hFFFF;
                pats[2] = 16'h8001;
                pats[3] = 16'h5A5A;
                pats[4] = 16'($urandom);
                for (int p = 0; p < 5; p++) begin
                    exp = model(pats[p], 4'(n), 2'(op));
                    issue(pats[p], 4'(n), 2'(op));
                    wait_done(1, cyc);
                    tests_run++;
                    if (cyc !== n + 1 || Out !== exp) begin
                        tests_failed++;
                        $display("FAIL sweep op=%0d cnt=%0d in=%h: cycle=%0d Out=%h, want cycle=%0d Out=%h",
                                 op, n, pats[p], cyc, Out, n + 1, exp);
                    end
                    // Alternate between back-to-back and idle gaps.
                    if ($urandom_range(0, 1) == 1) @(negedge clk);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        In    = 16'h0000;
        Cnt   = 4'd0;
        Op    = 2'b00;
        test_reset();
        test_rol_basic();
        test_sra_max();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
